// File: rtl/gost_28147_89_mode_ctrl.sv
// Mode sequencer (ECB / gamma-CTR / optional CFB) in front of a single gost_28147_89 core.
// Optional CFB support is compiled in when GOST_CTRL_CFB_EN is defined.
module gost_28147_89_mode_ctrl #(
  parameter int   TIMEOUT  = 40,
  parameter logic SBOX_SEL = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [1:0]   cfg_mode_i,
  input  logic         cfg_dir_i,
  input  logic         cfg_key_we_i,
  input  logic [255:0] cfg_key_i,
  input  logic         cfg_iv_we_i,
  input  logic [63:0]  cfg_iv_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [63:0]  in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [63:0]  out_data_o,
  output logic         busy_o,
  output logic         err_o,
  output logic         core_kload_o,
  output logic [255:0] core_key_o,
  output logic         core_load_o,
  output logic [63:0]  core_pdata_o,
  output logic         core_mode_o,
  output logic         core_select_o,
  input  logic         core_done_i,
  input  logic [63:0]  core_cdata_i
);

  // state   | meaning
  // IDLE    | no message open (after reset, illegal mode or watchdog)
  // PREP    | CTR only: core encrypting the IV into the counter n
  // WAIT_IN | message open, waiting for an input block
  // RUN     | core processing the accepted block
  // OUT     | result held on out_data until out_ready
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PREP    = 3'd1,
    ST_WAIT_IN = 3'd2,
    ST_RUN     = 3'd3,
    ST_OUT     = 3'd4
  } state_e;

  localparam logic [1:0] MODE_ECB = 2'b00;
  localparam logic [1:0] MODE_CTR = 2'b01;
`ifdef GOST_CTRL_CFB_EN
  localparam logic [1:0] MODE_CFB = 2'b10;
`endif

  localparam int            WdW     = $clog2(TIMEOUT + 1);
  localparam logic [WdW-1:0] WD_INIT = WdW'(TIMEOUT - 1);

  state_e         state_q;
  logic [1:0]     mode_q;
  logic           dir_q;
  logic           err_q;
  logic           kload_q;
  logic [255:0]   key_q;
  logic           load_q;
  logic [63:0]    pdata_q;
  logic [63:0]    n_q;
  logic [63:0]    in_buf_q;
  logic [63:0]    out_data_q;
  logic           out_valid_q;
  logic [WdW-1:0] wd_q;
`ifdef GOST_CTRL_CFB_EN
  logic [63:0]    fb_q;
`endif

  logic        open_st;
  logic        done_ok;
  logic [32:0] hi_sum;
  logic [63:0] n_step_d;
  logic [63:0] pdata_d;
  logic [63:0] result_d;

  assign open_st = (state_q == ST_IDLE) || (state_q == ST_WAIT_IN);
  // A done seen while our own load pulse is still out belongs to an earlier operation.
  assign done_ok = core_done_i && !load_q;

  // Low word steps mod 2^32, high word mod 2^32-1 via end-around carry.
  assign hi_sum   = {1'b0, n_q[63:32]} + 33'h0_0101_0104;
  assign n_step_d = {hi_sum[31:0] + {31'd0, hi_sum[32]}, n_q[31:0] + 32'h0101_0101};

  always_comb begin
    pdata_d = in_data_i;
    case (mode_q)
      MODE_CTR: pdata_d = n_step_d;
`ifdef GOST_CTRL_CFB_EN
      MODE_CFB: pdata_d = fb_q;
`endif
      default:  pdata_d = in_data_i;
    endcase
  end

  always_comb begin
    result_d = core_cdata_i;
    if (mode_q != MODE_ECB) result_d = in_buf_q ^ core_cdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      mode_q      <= 2'b00;
      dir_q       <= 1'b0;
      err_q       <= 1'b0;
      kload_q     <= 1'b0;
      key_q       <= '0;
      load_q      <= 1'b0;
      pdata_q     <= '0;
      n_q         <= '0;
      in_buf_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      wd_q        <= '0;
`ifdef GOST_CTRL_CFB_EN
      fb_q        <= '0;
`endif
    end else begin
      kload_q <= 1'b0;
      load_q  <= 1'b0;

      if (cfg_key_we_i) begin
        if (open_st) begin
          kload_q <= 1'b1;
          key_q   <= cfg_key_i;
        end else begin
          err_q <= 1'b1;
        end
      end

      case (state_q)
        ST_IDLE, ST_WAIT_IN: begin
          // A new IV wins over a simultaneous input handshake.
          if (cfg_iv_we_i) begin
            mode_q <= cfg_mode_i;
            dir_q  <= cfg_dir_i;
            err_q  <= 1'b0;
            case (cfg_mode_i)
              MODE_ECB: state_q <= ST_WAIT_IN;
              MODE_CTR: begin
                pdata_q <= cfg_iv_i;
                load_q  <= 1'b1;
                wd_q    <= WD_INIT;
                state_q <= ST_PREP;
              end
`ifdef GOST_CTRL_CFB_EN
              MODE_CFB: begin
                fb_q    <= cfg_iv_i;
                state_q <= ST_WAIT_IN;
              end
`endif
              default: begin
                err_q   <= 1'b1;
                state_q <= ST_IDLE;
              end
            endcase
          end else if ((state_q == ST_WAIT_IN) && in_valid_i) begin
            in_buf_q <= in_data_i;
            pdata_q  <= pdata_d;
            load_q   <= 1'b1;
            wd_q     <= WD_INIT;
            state_q  <= ST_RUN;
            if (mode_q == MODE_CTR) n_q <= n_step_d;
          end
        end

        ST_PREP: begin
          if (cfg_iv_we_i) err_q <= 1'b1;
          if (done_ok) begin
            n_q     <= core_cdata_i;
            state_q <= ST_WAIT_IN;
          end else if (wd_q == '0) begin
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            wd_q <= wd_q - WdW'(1);
          end
        end

        ST_RUN: begin
          if (cfg_iv_we_i) err_q <= 1'b1;
          if (done_ok) begin
            out_data_q  <= result_d;
            out_valid_q <= 1'b1;
            state_q     <= ST_OUT;
`ifdef GOST_CTRL_CFB_EN
            if (mode_q == MODE_CFB) fb_q <= dir_q ? in_buf_q : result_d;
`endif
          end else if (wd_q == '0) begin
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            wd_q <= wd_q - WdW'(1);
          end
        end

        ST_OUT: begin
          if (cfg_iv_we_i) err_q <= 1'b1;
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_WAIT_IN;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready_o    = (state_q == ST_WAIT_IN);
  assign busy_o        = !open_st;
  assign out_valid_o   = out_valid_q;
  assign out_data_o    = out_data_q;
  assign err_o         = err_q;
  assign core_kload_o  = kload_q;
  assign core_key_o    = key_q;
  assign core_load_o   = load_q;
  assign core_pdata_o  = pdata_q;
  // Stream modes only ever run the core forwards.
  assign core_mode_o   = (mode_q == MODE_ECB) && dir_q;
  assign core_select_o = SBOX_SEL;

endmodule
